contador_multicarril: RTL and testbench
=======================================

Name: contador_multicarril

Overview:
- Parking-lot occupancy counter for N_LANES independent bidirectional lanes. Each lane has two sensors: S1 on the outer side and S2 on the inner side.
- Per lane, the block debounces both sensors and decodes direction with an FSM. It counts only complete transits, so reversals and aborted transits never change the count.
- Keeps one shared occupancy count, saturating at 0 and at CAPACITY, and presents it as BCD.
- Sits between the raw sensor pins and the existing 7-segment multiplexer, which consumes count_bcd.

Parameters:
- N_LANES, 2, number of lanes (1..8).
- CAPACITY, 150, maximum occupancy; must be at most 10**DIGITS-1.
- DIGITS, 3, number of BCD digits on count_bcd.
- DEBOUNCE_COUNT, 100000, number of consecutive stable cycles before a debounced sensor changes.
- CW, $clog2(CAPACITY+1), width of the binary count.

Ports:
- clk  in  1  system clock.
- reset_btn  in  1  synchronous, active-low reset.
- S1  in  N_LANES  raw outer sensors, asynchronous, 1 = beam blocked.
- S2  in  N_LANES  raw inner sensors, asynchronous, 1 = beam blocked.
- count_bin  out  CW  binary occupancy.
- count_bcd  out  4*DIGITS  BCD occupancy; least significant digit in [3:0].
- full  out  1  high while count_bin == CAPACITY.
- empty  out  1  high while count_bin == 0.
- vehicle_entered  out  N_LANES  1-cycle pulse per lane on a completed entry.
- vehicle_exited  out  N_LANES  1-cycle pulse per lane on a completed exit.
- abort  out  N_LANES  1-cycle pulse per lane when a transit is abandoned.
- rejected  out  1  1-cycle pulse when an entry or exit is dropped by saturation.

Behaviour:
- Reset applies on a clk edge with reset_btn == 0:
  - all FSMs go to IDLE; debouncers, synchronisers and their counters clear; debounced sensors = 0;
  - count_bin = 0, count_bcd = 0, empty = 1;
  - full, all pulse outputs and rejected = 0.
- Reset asserted mid-transit discards the transit; no pulse is produced.
- Input conditioning, per sensor:
  - 2-FF synchroniser, then debounce.
  - The debounced value takes the synchronised value only after it has differed for DEBOUNCE_COUNT consecutive cycles.
  - Any glitch resets the stability counter.
- Lane FSM works on debounced (S1,S2). States: IDLE, ENT1, ENT2, ENT3, EXT1, EXT2, EXT3.
- Transitions out of IDLE:
  - (1,0) -> ENT1; (0,1) -> EXT1.
  - (1,1) stays in IDLE: both sensors at once is ambiguous and is never counted.
- Entry path:
  - ENT1: (1,1) -> ENT2; (0,0) -> IDLE with abort; (0,1) -> IDLE with abort.
  - ENT2: (0,1) -> ENT3; (1,0) -> ENT1 (reversing); (0,0) -> IDLE with abort.
  - ENT3: (0,0) -> IDLE with vehicle_entered; (1,1) -> ENT2; (1,0) -> IDLE with abort.
- Exit path is the mirror of the entry path with S1 and S2 swapped; completion pulses vehicle_exited.
- All pulses are registered and appear the cycle after the FSM sees the final sensor value.
- Count update, one cycle after the pulses:
  - ne = popcount(vehicle_entered), nx = popcount(vehicle_exited).
  - next = count_bin + ne - nx, computed signed with width CW+4, then clamped to [0, CAPACITY].
  - rejected = 1 when clamping removed at least one event.
  - Opposing events in the same cycle cancel before clamping. Example: at full, one entry plus one exit in the same cycle gives no change and no rejected.
- BCD tracking:
  - count_bcd steps by at most ±1 per cycle toward count_bin, using a per-digit carry/borrow chain (9 -> 0 carry, 0 -> 9 borrow).
  - count_bcd equals count_bin in BCD within N_LANES cycles of any update.
  - full and empty are derived from count_bin, not from count_bcd.
- Lanes are fully independent. Simultaneous completions on all lanes are legal and must all be counted.

Decomposition:
- Package contador_pkg holds:
  - typedef enum lane_state_t {IDLE, ENT1, ENT2, ENT3, EXT1, EXT2, EXT3};
  - function popcount;
  - localparam BCD_W = 4.
- Sub-module lane_detector holds the synchroniser, the debouncers for S1/S2 and the lane FSM.
  - It takes DEBOUNCE_COUNT as a parameter.
  - It outputs vehicle_entered, vehicle_exited and abort for one lane.
  - The top level instantiates it N_LANES times in a generate loop and holds the saturating counter and the BCD tracker.

Test Plan:
Common setup: N_LANES=2, CAPACITY=5, DIGITS=2, DEBOUNCE_COUNT=4.
- Reset: hold reset_btn=0 for 3 cycles with the sensors toggling -> count_bcd=8'h00, empty=1, no pulses.
- Entry: 3 clean entries on lane 0 (S1; S1+S2; S2; none, each phase held 20 cycles) -> 3 vehicle_entered[0] pulses, count_bin=3, count_bcd=8'h03.
- Abort and reversal, lane 1:
  - S1 up then down -> abort[1] pulse, count unchanged.
  - S1, S1+S2, S1, none -> abort[1] pulse, count unchanged.
  - 2 ns glitches on S2 -> no state change.
- Saturation: from 4, a simultaneous entry on both lanes -> count_bin=5, full=1, rejected pulse. A further entry -> rejected, count stays 5. One exit -> count 4, full=0.
- Concurrency: at count 5, an entry on lane 0 and an exit on lane 1 in the same cycle -> count stays 5, no rejected. From 0, an exit -> rejected, count stays 0, empty=1.
- Reset mid-transit: drive ENT2 on lane 0, pulse reset_btn low for 1 cycle -> count 0, no vehicle_entered when the sensors later clear.

Source files
------------

// File: rtl/contador_pkg.sv
// contador_pkg: shared lane state encoding, BCD digit width and event popcount
package contador_pkg;
  localparam int BCD_W = 4;
  typedef enum logic [2:0] {IDLE, ENT1, ENT2, ENT3, EXT1, EXT2, EXT3} lane_state_t;
  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n += {3'b000, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/lane_detector.sv
// lane_detector: synchronises and debounces one lane's S1/S2 and decodes complete transits
module lane_detector import contador_pkg::*; #(
  parameter int DEBOUNCE_COUNT = 100000
) (
  input  logic clk,
  input  logic reset_btn,
  input  logic s1,
  input  logic s2,
  output logic vehicle_entered,
  output logic vehicle_exited,
  output logic abort
);
  localparam int DW = $clog2(DEBOUNCE_COUNT + 1);
  logic [1:0] meta_q, sync_q, db_q, db_d, sd;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  lane_state_t state_q;
  assign sd = {db_q[0], db_q[1]};
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = (sync_q[i] == db_q[i]) ? '0 : cnt_q[i] + 1'b1;
      if (cnt_d[i] == DW'(DEBOUNCE_COUNT)) begin
        db_d[i] = sync_q[i];
        cnt_d[i] = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_btn) begin
      meta_q <= '0;
      sync_q <= '0;
      db_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      meta_q <= {s2, s1};
      sync_q <= meta_q;
      db_q <= db_d;
      cnt_q <= cnt_d;
    end
  end
  // sd is {S1,S2}; the exit path mirrors the entry path with the bits swapped
  always_ff @(posedge clk) begin
    if (!reset_btn) begin
      state_q <= IDLE;
      vehicle_entered <= 1'b0;
      vehicle_exited <= 1'b0;
      abort <= 1'b0;
    end else begin
      vehicle_entered <= 1'b0;
      vehicle_exited <= 1'b0;
      abort <= 1'b0;
      case (state_q)
        IDLE: state_q <= (sd == 2'b10) ? ENT1 : (sd == 2'b01) ? EXT1 : IDLE;
        ENT1:
          if (sd == 2'b11) state_q <= ENT2;
          else if (sd != 2'b10) begin
            state_q <= IDLE;
            abort <= 1'b1;
          end
        ENT2:
          if (sd == 2'b01) state_q <= ENT3;
          else if (sd == 2'b10) state_q <= ENT1;
          else if (sd == 2'b00) begin
            state_q <= IDLE;
            abort <= 1'b1;
          end
        ENT3:
          if (sd == 2'b00) begin
            state_q <= IDLE;
            vehicle_entered <= 1'b1;
          end else if (sd == 2'b11) state_q <= ENT2;
          else if (sd == 2'b10) begin
            state_q <= IDLE;
            abort <= 1'b1;
          end
        EXT1:
          if (sd == 2'b11) state_q <= EXT2;
          else if (sd != 2'b01) begin
            state_q <= IDLE;
            abort <= 1'b1;
          end
        EXT2:
          if (sd == 2'b10) state_q <= EXT3;
          else if (sd == 2'b01) state_q <= EXT1;
          else if (sd == 2'b00) begin
            state_q <= IDLE;
            abort <= 1'b1;
          end
        EXT3:
          if (sd == 2'b00) begin
            state_q <= IDLE;
            vehicle_exited <= 1'b1;
          end else if (sd == 2'b11) state_q <= EXT2;
          else if (sd == 2'b01) begin
            state_q <= IDLE;
            abort <= 1'b1;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/contador_multicarril.sv
// contador_multicarril: multi-lane parking occupancy counter with saturation and BCD tracking
module contador_multicarril import contador_pkg::*; #(
  parameter int N_LANES = 2,
  parameter int CAPACITY = 150,
  parameter int DIGITS = 3,
  parameter int DEBOUNCE_COUNT = 100000,
  parameter int CW = $clog2(CAPACITY + 1)
) (
  input  logic clk,
  input  logic reset_btn,
  input  logic [N_LANES-1:0] S1,
  input  logic [N_LANES-1:0] S2,
  output logic [CW-1:0] count_bin,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic full,
  output logic empty,
  output logic [N_LANES-1:0] vehicle_entered,
  output logic [N_LANES-1:0] vehicle_exited,
  output logic [N_LANES-1:0] abort,
  output logic rejected
);
  localparam logic signed [CW+3:0] CAP_S = (CW + 4)'(CAPACITY);
  logic [CW-1:0] count_q, count_d, track_q, track_d;
  logic [BCD_W*DIGITS-1:0] bcd_q, bcd_d;
  logic rejected_q, rejected_d, up, dn, c;
  logic [3:0] ne, nx;
  logic signed [CW+3:0] sum;
  logic [BCD_W-1:0] dig;
  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    lane_detector #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_lane (
      .clk(clk),
      .reset_btn(reset_btn),
      .s1(S1[g]),
      .s2(S2[g]),
      .vehicle_entered(vehicle_entered[g]),
      .vehicle_exited(vehicle_exited[g]),
      .abort(abort[g])
    );
  end
  always_comb begin
    ne = popcount(8'(vehicle_entered));
    nx = popcount(8'(vehicle_exited));
    sum = $signed({4'b0000, count_q}) + $signed({{CW{1'b0}}, ne}) - $signed({{CW{1'b0}}, nx});
    rejected_d = (sum < 0) || (sum > CAP_S);
    count_d = (sum < 0) ? '0 : (sum > CAP_S) ? CW'(CAPACITY) : CW'(sum);
  end
  // track_q mirrors the value held in bcd_q so the step direction is a binary compare
  always_comb begin
    up = track_q < count_q;
    dn = track_q > count_q;
    track_d = up ? track_q + 1'b1 : dn ? track_q - 1'b1 : track_q;
    bcd_d = bcd_q;
    c = up | dn;
    dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = bcd_q[i*BCD_W +: BCD_W];
      if (c) begin
        bcd_d[i*BCD_W +: BCD_W] = up ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1)
                                     : ((dig == 4'd0) ? 4'd9 : dig - 4'd1);
        c = up ? (dig == 4'd9) : (dig == 4'd0);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_btn) begin
      count_q <= '0;
      track_q <= '0;
      bcd_q <= '0;
      rejected_q <= 1'b0;
    end else begin
      count_q <= count_d;
      track_q <= track_d;
      bcd_q <= bcd_d;
      rejected_q <= rejected_d;
    end
  end
  assign count_bin = count_q;
  assign count_bcd = bcd_q;
  assign rejected = rejected_q;
  assign full = count_q == CW'(CAPACITY);
  assign empty = count_q == '0;
endmodule

// File: tb/tb_contador_multicarril.sv
// tb_contador_multicarril: directed vectors for the occupancy counter with hand-computed expectations
module tb_contador_multicarril;
  logic clk = 1'b0;
  logic reset_btn = 1'b0;
  logic [1:0] S1 = '0, S2 = '0;
  logic [2:0] count_bin;
  logic [7:0] count_bcd;
  logic full, empty, rejected;
  logic [1:0] vehicle_entered, vehicle_exited, abort;
  int vecs = 0, errs = 0;
  int ent_n[2] = '{0, 0};
  int ext_n[2] = '{0, 0};
  int ab_n[2] = '{0, 0};
  int rej_n = 0;
  contador_multicarril #(.N_LANES(2), .CAPACITY(5), .DIGITS(2), .DEBOUNCE_COUNT(4)) dut (
    .clk(clk),
    .reset_btn(reset_btn),
    .S1(S1),
    .S2(S2),
    .count_bin(count_bin),
    .count_bcd(count_bcd),
    .full(full),
    .empty(empty),
    .vehicle_entered(vehicle_entered),
    .vehicle_exited(vehicle_exited),
    .abort(abort),
    .rejected(rejected)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (vehicle_entered[l] === 1'b1) ent_n[l]++;
      if (vehicle_exited[l] === 1'b1) ext_n[l]++;
      if (abort[l] === 1'b1) ab_n[l]++;
    end
    if (rejected === 1'b1) rej_n++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic phase(input logic [1:0] a, input logic [1:0] b);
    @(negedge clk);
    S1 = a;
    S2 = b;
    repeat (20) @(negedge clk);
  endtask
  // e: lanes doing an entry, x: lanes doing an exit, all in lockstep
  task automatic xfer(input logic [1:0] e, input logic [1:0] x);
    phase(e, x);
    phase(e | x, e | x);
    phase(x, e);
    phase(2'b00, 2'b00);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      S1 = 2'($urandom);
      S2 = ~S1;
    end
    chk("rst_bcd", count_bcd, 8'h00);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rej", rejected, 0);
    S1 = '0;
    S2 = '0;
    @(negedge clk);
    reset_btn = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_bin", count_bin, 0);
    chk("rst_pulses", ent_n[0] + ent_n[1] + ext_n[0] + ext_n[1] + ab_n[0] + ab_n[1] + rej_n, 0);
    repeat (3) xfer(2'b01, 2'b00);
    chk("ent_pulses", ent_n[0], 3);
    chk("ent_bin", count_bin, 3);
    chk("ent_bcd", count_bcd, 8'h03);
    chk("ent_empty", empty, 0);
    phase(2'b10, 2'b00);
    phase(2'b00, 2'b00);
    chk("abort_n", ab_n[1], 1);
    chk("abort_bin", count_bin, 3);
    phase(2'b10, 2'b00);
    phase(2'b10, 2'b10);
    phase(2'b10, 2'b00);
    phase(2'b00, 2'b00);
    chk("rev_abort_n", ab_n[1], 2);
    chk("rev_ent1", ent_n[1], 0);
    chk("rev_bin", count_bin, 3);
    repeat (3) begin
      @(negedge clk);
      S2[1] = 1'b1;
      #2 S2[1] = 1'b0;
    end
    @(negedge clk);
    S2[1] = 1'b1;
    repeat (3) @(negedge clk);
    S2[1] = 1'b0;
    @(negedge clk);
    S2[1] = 1'b1;
    repeat (3) @(negedge clk);
    S2[1] = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_abort", ab_n[1], 2);
    chk("glitch_exit", ext_n[1], 0);
    chk("glitch_bin", count_bin, 3);
    xfer(2'b01, 2'b00);
    chk("to4_bin", count_bin, 4);
    xfer(2'b11, 2'b00);
    chk("sat_bin", count_bin, 5);
    chk("sat_full", full, 1);
    chk("sat_rej", rej_n, 1);
    chk("sat_ent1", ent_n[1], 1);
    chk("sat_bcd", count_bcd, 8'h05);
    xfer(2'b10, 2'b00);
    chk("sat2_rej", rej_n, 2);
    chk("sat2_bin", count_bin, 5);
    chk("sat2_ent1", ent_n[1], 2);
    xfer(2'b00, 2'b01);
    chk("ex_bin", count_bin, 4);
    chk("ex_full", full, 0);
    chk("ex_ext0", ext_n[0], 1);
    chk("ex_bcd", count_bcd, 8'h04);
    xfer(2'b01, 2'b00);
    chk("refill_bin", count_bin, 5);
    chk("refill_rej", rej_n, 2);
    xfer(2'b01, 2'b10);
    chk("conc_bin", count_bin, 5);
    chk("conc_rej", rej_n, 2);
    chk("conc_ent0", ent_n[0], 7);
    chk("conc_ext1", ext_n[1], 1);
    chk("conc_bcd", count_bcd, 8'h05);
    phase(2'b01, 2'b00);
    phase(2'b01, 2'b01);
    @(negedge clk);
    reset_btn = 1'b0;
    @(negedge clk);
    reset_btn = 1'b1;
    repeat (20) @(negedge clk);
    phase(2'b00, 2'b00);
    chk("mid_ent0", ent_n[0], 7);
    chk("mid_abort0", ab_n[0], 0);
    chk("mid_bin", count_bin, 0);
    chk("mid_bcd", count_bcd, 8'h00);
    chk("mid_empty", empty, 1);
    xfer(2'b00, 2'b10);
    chk("under_rej", rej_n, 3);
    chk("under_bin", count_bin, 0);
    chk("under_empty", empty, 1);
    chk("under_ext1", ext_n[1], 2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
